// File: rtl/boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package boot_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StData,
    StChk,
    StDone,
    StErr
  } boot_state_e;

  localparam int unsigned LEN_BYTES  = 4;
  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/byte_assembler.sv
// Collects little-endian bytes into a 32-bit word; word_valid_o flags the byte that completes it.
module byte_assembler
  import boot_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr_i,
  input  logic        valid_i,
  input  logic [7:0]  data_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] shift_q, shift_d;

  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (clr_i) begin
      cnt_d   = '0;
      shift_d = '0;
    end else if (valid_i) begin
      cnt_d   = cnt_q + 2'd1;
      shift_d = {data_i, shift_q[31:8]};
    end
  end

  // The completing byte is merged combinationally so the word is usable in its arrival cycle.
  assign word_valid_o = valid_i && !clr_i && (cnt_q == 2'(WORD_BYTES - 1));
  assign word_o       = {data_i, shift_q[31:8]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Streams a length-prefixed image into instruction memory while holding the core in reset.
// Optional trailing XOR checksum byte enabled by defining BOOT_CHECKSUM_EN.
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam logic [32:0] Capacity = 33'(1) << ADDR_WIDTH;
`ifdef BOOT_CHECKSUM_EN
  localparam boot_state_e TailSt = StChk;
`else
  localparam boot_state_e TailSt = StDone;
`endif

  boot_state_e           state_q, state_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [ADDR_WIDTH:0]   wcnt_q, wcnt_d;
  logic                  ready_q, ready_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  hold_q, hold_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]            csum_q, csum_d;
`endif

  logic        xfer;
  logic        asm_clr, asm_valid, asm_word_valid;
  logic [31:0] asm_word;

  assign xfer = rx_valid && ready_q;

  byte_assembler u_asm (
    .clk          (clk),
    .reset        (reset),
    .clr_i        (asm_clr),
    .valid_i      (asm_valid),
    .data_i       (rx_data),
    .word_valid_o (asm_word_valid),
    .word_o       (asm_word)
  );

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    wcnt_d    = wcnt_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    asm_clr   = 1'b0;
    asm_valid = 1'b0;
`ifdef BOOT_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d = StLen;
          asm_clr = 1'b1;
          wcnt_d  = '0;
`ifdef BOOT_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      StLen: begin
        asm_valid = xfer;
        if (asm_word_valid) begin
          len_d = asm_word[ADDR_WIDTH:0];
          if ({1'b0, asm_word} > Capacity) begin
            state_d = StErr;
          end else if (asm_word == '0) begin
            state_d = TailSt;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        asm_valid = xfer;
        if (asm_word_valid) begin
          we_d    = 1'b1;
          addr_d  = wcnt_q[ADDR_WIDTH-1:0];
          wdata_d = asm_word;
          wcnt_d  = wcnt_q + 1'b1;
          if (wcnt_q == len_q - (ADDR_WIDTH + 1)'(1)) begin
            state_d = TailSt;
          end
        end
      end
`ifdef BOOT_CHECKSUM_EN
      StChk: begin
        if (xfer) begin
          state_d = (rx_data == csum_q) ? StDone : StErr;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
`ifdef BOOT_CHECKSUM_EN
    if (xfer && (state_q == StLen || state_q == StData)) begin
      csum_d = csum_q ^ rx_data;
    end
`endif
  end

  // Status outputs are registered images of the next state.
  always_comb begin
    ready_d = state_d inside {StLen, StData, StChk};
    busy_d  = ready_d;
    done_d  = (state_d == StDone);
    err_d   = (state_d == StErr);
    hold_d  = (state_d != StDone);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      len_q   <= '0;
      wcnt_q  <= '0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      hold_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      wcnt_q  <= wcnt_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef BOOT_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign rx_ready   = ready_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_hold   = hold_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomised bench for imem_boot_loader against an image-level reference model.
module tb_imem_boot_loader;

  localparam int unsigned AW  = 4;
  localparam int unsigned Cap = 1 << AW;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int unsigned addr;
    logic [31:0] data;
  } wr_t;

  logic          clk, reset, start, rx_valid, rx_ready;
  logic [7:0]    rx_data;
  logic          imem_we, cpu_hold, busy, done, error;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;

  int  n_checks = 0;
  int  n_fail   = 0;
  wr_t got[$];
  wr_t exp_wr[$];
  bit  exp_done, exp_err;
  bq_t img;

  imem_boot_loader #(.ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    wr_t w;
    #1;
    if (imem_we === 1'b1) begin
      w.addr = int'(imem_addr);
      w.data = imem_wdata;
      got.push_back(w);
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_checks++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got_v, exp_v);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_ready"}, rx_ready, 0);
    check_val({tag, "_we"}, imem_we, 0);
    check_val({tag, "_addr"}, imem_addr, 0);
    check_val({tag, "_wdata"}, imem_wdata, 0);
    check_val({tag, "_hold"}, cpu_hold, 1);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_done"}, done, 0);
    check_val({tag, "_error"}, error, 0);
  endtask

  // Reference: decode the image by its format rules.
  task automatic model(input bq_t q);
    logic [31:0] n;
    logic [7:0]  x;
    wr_t         w;
    exp_wr.delete();
    exp_done = 0;
    exp_err  = 0;
    n = {q[3], q[2], q[1], q[0]};
    if (n > Cap) begin
      exp_err = 1;
      return;
    end
    for (int i = 0; i < int'(n); i++) begin
      w.addr = i;
      w.data = {q[4+4*i+3], q[4+4*i+2], q[4+4*i+1], q[4+4*i]};
      exp_wr.push_back(w);
    end
`ifdef BOOT_CHECKSUM_EN
    x = 8'h00;
    for (int j = 0; j < 4 + 4 * int'(n); j++) x ^= q[j];
    if (q[4+4*int'(n)] == x) exp_done = 1;
    else exp_err = 1;
`else
    x = 8'h00;
    exp_done = (x == 8'h00);
`endif
  endtask

  task automatic make_image(input logic [31:0] n, input bit bad_csum);
    logic [31:0] w;
    logic [7:0]  x;
    int          nw;
    img.delete();
    x = 8'h00;
    for (int b = 0; b < 4; b++) begin
      img.push_back(n[8*b+:8]);
      x ^= n[8*b+:8];
    end
    nw = (n > Cap) ? 1 : int'(n);
    for (int i = 0; i < nw; i++) begin
      w = $urandom;
      for (int b = 0; b < 4; b++) begin
        img.push_back(w[8*b+:8]);
        x ^= w[8*b+:8];
      end
    end
`ifdef BOOT_CHECKSUM_EN
    img.push_back(bad_csum ? (x ^ 8'(1 + $urandom_range(0, 254))) : x);
`else
    if (bad_csum) img.push_back(8'hA5);
`endif
  endtask

  task automatic pulse_start();
    rx_valid = 1'b0;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send_bytes(input bq_t q, input int max_gap, input int start_at);
    int t;
    for (int i = 0; i < q.size(); i++) begin
      if (i == start_at) pulse_start();
      rx_valid = 1'b0;
      repeat ($urandom_range(0, max_gap)) begin
        @(posedge clk);
        #1;
      end
      rx_data  = q[i];
      rx_valid = 1'b1;
      t = 0;
      while (!rx_ready && !done && !error && t < 200) begin
        @(posedge clk);
        #1;
        t++;
      end
      if (!rx_ready) begin
        if (!done && !error) check_val("rx_stall_timeout", 0, 1);
        break;
      end
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
  endtask

  task automatic finish_and_compare(input string tag, input bq_t q);
    int t = 0;
    while (!done && !error && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    check_val({tag, "_end_seen"}, 32'(done || error), 1);
    repeat (2) @(posedge clk);
    #2;
    model(q);
    check_val({tag, "_done"}, done, 32'(exp_done));
    check_val({tag, "_error"}, error, 32'(exp_err));
    check_val({tag, "_hold"}, cpu_hold, 32'(!exp_done));
    check_val({tag, "_ready"}, rx_ready, 0);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_nwr"}, got.size(), exp_wr.size());
    for (int i = 0; i < got.size() && i < exp_wr.size(); i++) begin
      check_val({tag, "_addr"}, got[i].addr, exp_wr[i].addr);
      check_val({tag, "_data"}, got[i].data, exp_wr[i].data);
    end
  endtask

  task automatic run_image(input string tag, input bq_t q, input int max_gap, input int start_at);
    pulse_start();
    check_val({tag, "_hold_start"}, cpu_hold, 1);
    check_val({tag, "_busy_start"}, busy, 1);
    check_val({tag, "_done_clr"}, done, 0);
    check_val({tag, "_err_clr"}, error, 0);
    got.delete();
    send_bytes(q, max_gap, start_at);
    finish_and_compare(tag, q);
  endtask

  initial begin
    bq_t part;
    reset    = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst");
    reset = 1'b0;
    @(posedge clk);
    #1;

    img = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
            8'h93, 8'h00, 8'h50, 8'h00};
`ifdef BOOT_CHECKSUM_EN
    img.push_back(8'hD2);
`endif
    run_image("n2", img, 0, -1);
    check_val("n2_w0", got[0].data, 32'h0000_0013);
    check_val("n2_w1", got[1].data, 32'h0050_0093);
    check_val("n2_a1", got[1].addr, 1);
    run_image("n2_gap", img, 5, -1);
    run_image("n2_busy_start", img, 2, 6);

    // Reset mid-load: 4 length bytes plus 6 data bytes, one word already written.
    pulse_start();
    got.delete();
    part = img[0:9];
    send_bytes(part, 0, -1);
    check_val("mid_nwr", got.size(), 1);
    #2;
    reset = 1'b1;
    #1;
    check_reset_vals("async_rst");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    run_image("after_rst", img, 1, -1);
    check_val("after_rst_a0", got[0].addr, 0);

`ifdef BOOT_CHECKSUM_EN
    img[12] = 8'hD3;
    run_image("bad_csum", img, 0, -1);
    img[12] = 8'hD2;
    run_image("good_csum", img, 0, -1);
`endif

    img = '{8'h00, 8'h00, 8'h00, 8'h00};
`ifdef BOOT_CHECKSUM_EN
    img.push_back(8'h00);
`endif
    run_image("n0", img, 0, -1);

    make_image(32'(Cap + 1), 0);
    run_image("oversize", img, 0, -1);
    make_image(32'(Cap), 0);
    run_image("full", img, 1, -1);

    for (int k = 0; k < 12; k++) begin
      logic [31:0] n;
      n = (k % 5 == 4) ? (32'(Cap + 1) + 32'($urandom_range(0, 70000)))
                       : 32'($urandom_range(0, Cap));
      make_image(n, ($urandom_range(0, 3) == 0));
      run_image("rand", img, $urandom_range(0, 5), -1);
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
Boot-time program loader that sits directly upstream of the instruction memory in the single-cycle RISC-V core. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and writes them sequentially into instruction memory starting at word 0. While loading, it holds the core in reset. It releases the core only after a complete, well-formed image has been written.

Parameters:
ADDR_WIDTH, 10, instruction memory word-address width; capacity = 2**ADDR_WIDTH words

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle pulse; begins a load from IDLE, DONE or ERR
rx_data  input  8  incoming image byte
rx_valid  input  1  rx_data valid
rx_ready  output  1  loader accepts a byte; a transfer occurs when rx_valid && rx_ready
imem_we  output  1  instruction memory write strobe, one cycle per word
imem_addr  output  ADDR_WIDTH  word address of the current write
imem_wdata  output  32  assembled instruction word
cpu_hold  output  1  holds the processor (PC and register file) in reset
busy  output  1  high in LEN/DATA/CHK
done  output  1  image loaded successfully
error  output  1  image rejected

Behaviour:
- Clock and reset: one clock domain; clk; reset is asynchronous, active-high.
- Reset values: state=IDLE, rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, busy=0, done=0, error=0. All outputs are registered.
- Image format: 4-byte word count N (LSB first), then N words of 4 bytes each (LSB first), then, only with the feature enabled, 1 checksum byte.
- IDLE:
  - rx_ready=0.
  - start -> LEN; clears the byte counter, word counter, running XOR, done and error; sets cpu_hold=1.
- LEN:
  - rx_ready=1; collects 4 bytes.
  - After the 4th byte: if N > 2**ADDR_WIDTH -> ERR; if N == 0 -> CHK when the feature is on, else DONE; otherwise -> DATA.
- DATA:
  - rx_ready=1.
  - When the 4th byte of a word is accepted, the next cycle has imem_we=1, imem_addr=word index, imem_wdata=assembled word. The strobe lasts exactly 1 cycle.
  - rx_ready stays high during the write cycle. The assembly register is separate from imem_wdata, so back-to-back bytes sustain one word per 4 cycles.
  - After word N-1 is accepted -> CHK (feature on) or DONE.
  - A completely full memory (N = 2**ADDR_WIDTH) is legal. The address never wraps.
- rx_valid low: the loader stalls indefinitely with no timeout. Partial-word state is retained.
- DONE: done=1, cpu_hold=0, rx_ready=0, busy=0. Stays here until start or reset.
- ERR: error=1, cpu_hold=1, rx_ready=0. Error is sticky until start or reset.
- start while busy: ignored.
- start in DONE or ERR: restarts the load; cpu_hold=1 from the next cycle.
- Reset mid-load: immediate return to the reset values. Words already written are not undone.

Optional Feature:
BOOT_CHECKSUM_EN
- Defined: a running XOR covers all length and data bytes. CHK accepts 1 byte; it goes to DONE if the byte equals the XOR, else to ERR.
- Undefined: the CHK state and XOR logic are absent. The stream ends after the last data byte, and the next byte is not accepted (rx_ready=0 in DONE).

Decomposition:
- Package boot_pkg: state enum (IDLE, LEN, DATA, CHK, DONE, ERR), LEN_BYTES=4, WORD_BYTES=4.
- Sub-module byte_assembler: 2-bit byte counter plus little-endian 32-bit collect register, with a word_valid pulse. It is reused for both the length field and the data words.

Test Plan:
- Load N=2: bytes 02 00 00 00 13 00 00 00 93 00 50 00 (plus D2 if BOOT_CHECKSUM_EN) -> writes addr0=0x00000013 and addr1=0x00500093, each with a 1-cycle imem_we; then done=1 and cpu_hold=0.
- N=0: bytes 00 00 00 00 (plus 00 with checksum) -> no imem_we; done=1.
- Oversize: N=2**ADDR_WIDTH+1 -> error=1, cpu_hold=1, no imem_we, rx_ready=0.
- Random rx_valid gaps of 0-5 cycles during the N=2 image -> identical writes and addresses; no lost or duplicated bytes.
- BOOT_CHECKSUM_EN with checksum byte D3 instead of D2 -> both words written, then error=1, done=0. A subsequent start plus the correct image -> done=1.
- Reset asserted after 6 data bytes -> all outputs return to their reset values asynchronously. A later start plus the full image -> correct writes from addr0.
